fir_stream_sequencer: RTL

Sequencer that drives the FIR filter sample stream. It generates a programmable sample-rate tick and walks a sample-ROM address counter that wraps every signal period. It aligns the FIR clock-enable to the ROM read latency, flushes the FIR pipeline with zero samples at the end of a run, and flags which FIR outputs carry real samples. It sits between the sample ROM and `top_level`, replacing free-running enable and address generation.

---
 rtl/fir_seq_pkg.sv | 27 ++
 rtl/fir_seq_tick_gen.sv | 36 +++
 rtl/fir_stream_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_pkg.sv
// Shared types and default constants for the FIR stream sequencer.
// Contents:
//   fir_seq_state_t : sequencer FSM states
//   fir_seq_tick_t  : one tick-pipeline stage {tick, zero_fill}
//   Def*            : default geometry/latency constants, also used by the testbench
package fir_seq_pkg;

  localparam int unsigned DefAddrWidth  = 8;
  localparam int unsigned DefPeriodLen  = 44;
  localparam int unsigned DefDivWidth   = 16;
  localparam int unsigned DefCntWidth   = 16;
  localparam int unsigned DefRomLatency = 1;
  localparam int unsigned DefFirLatency = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } fir_seq_state_t;

  typedef struct packed {
    logic tick;
    logic zero_fill;
  } fir_seq_tick_t;

endpackage

// File: rtl/fir_seq_tick_gen.sv
// Programmable sample-rate tick generator.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : latch iv_div (0 treated as 1) and force a tick on the next enabled cycle
//   iv_div       : clock cycles per tick
//   i_en         : count enable; ticks only occur while enabled
//   o_tick       : tick, asserted when enabled and the down-counter is at 0
module fir_seq_tick_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] iv_div,
  input  logic                 i_en,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] dc_q;

  assign o_tick = i_en && (dc_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= '0;
      dc_q  <= '0;
    end else if (i_load) begin
      div_q <= (iv_div == '0) ? DIV_WIDTH'(1) : iv_div;
      dc_q  <= '0;
    end else if (i_en) begin
      dc_q <= o_tick ? (div_q - DIV_WIDTH'(1)) : (dc_q - DIV_WIDTH'(1));
    end
  end

endmodule

// File: rtl/fir_stream_sequencer.sv
// FIR sample-stream sequencer: walks the sample-ROM address at a programmable rate,
// aligns the FIR enable to ROM latency, flushes the FIR with zero samples and tags
// which FIR outputs carry real samples.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_start, i_stop        : start (IDLE only), abort (RUN only)
//   iv_div, iv_num_periods : cycles per sample, periods to play (0 treated as 1)
//   ov_addr, o_rom_en      : sample-ROM address and read enable
//   o_fir_en, o_zero_fill  : FIR clock-enable and zero-input select
//   o_dout_valid           : FIR output holds a real-sample result
//   o_busy, o_done         : run in progress, completion pulse
module fir_stream_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned PERIOD_LEN  = DefPeriodLen,
  parameter int unsigned DIV_WIDTH   = DefDivWidth,
  parameter int unsigned CNT_WIDTH   = DefCntWidth,
  parameter int unsigned ROM_LATENCY = DefRomLatency,
  parameter int unsigned FIR_LATENCY = DefFirLatency
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [DIV_WIDTH-1:0]  iv_div,
  input  logic [CNT_WIDTH-1:0]  iv_num_periods,
  output logic [ADDR_WIDTH-1:0] ov_addr,
  output logic                  o_rom_en,
  output logic                  o_fir_en,
  output logic                  o_zero_fill,
  output logic                  o_dout_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned ZfWidth = $clog2(FIR_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(PERIOD_LEN - 1);
  localparam logic [ZfWidth-1:0] ZfCount = ZfWidth'(FIR_LATENCY);

  fir_seq_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  per_q, per_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [ZfWidth-1:0]    zf_q, zf_d;

  logic tick, tick_en, tick_load;
  logic run_tick, drain_tick;
  fir_seq_tick_t pipe_in;
  fir_seq_tick_t pipe_q [ROM_LATENCY];
  logic pipe_empty;
  logic [FIR_LATENCY-1:0] tag_q, tag_d;
  logic valid_q, done_q;

  assign tick_load = (state_q == StIdle) && i_start;
  // Drain ticks stop once every zero-fill sample has been issued.
  assign tick_en   = (state_q == StRun) || ((state_q == StDrain) && (zf_q < ZfCount));

  fir_seq_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (tick_load),
    .iv_div (iv_div),
    .i_en   (tick_en),
    .o_tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    per_d      = per_q;
    num_d      = num_q;
    zf_d       = zf_q;
    run_tick   = 1'b0;
    drain_tick = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRun;
          addr_d  = '0;
          per_d   = '0;
          zf_d    = '0;
          num_d   = (iv_num_periods == '0) ? CNT_WIDTH'(1) : iv_num_periods;
        end
      end
      StRun: begin
        // A tick coinciding with the stop is dropped so no ROM read follows the abort.
        if (i_stop) begin
          state_d = StDrain;
        end else if (tick) begin
          run_tick = 1'b1;
          if (addr_q == LastAddr) begin
            addr_d = '0;
            per_d  = per_q + CNT_WIDTH'(1);
            if (per_q == num_q - CNT_WIDTH'(1)) begin
              state_d = StDrain;
            end
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (tick) begin
          drain_tick = 1'b1;
          zf_d       = zf_q + ZfWidth'(1);
        end
        if ((zf_q == ZfCount) && pipe_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign pipe_in.tick      = run_tick || drain_tick;
  assign pipe_in.zero_fill = drain_tick;

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      if (pipe_q[i].tick) begin
        pipe_empty = 1'b0;
      end
    end
  end

  // Tag shift register mirrors the FIR pipeline: a tag leaves it when the sample it
  // marks reaches the FIR output.
  always_comb begin
    tag_d = tag_q;
    if (o_fir_en) begin
      tag_d[0] = ~o_zero_fill;
      for (int i = 1; i < FIR_LATENCY; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      per_q   <= '0;
      num_q   <= '0;
      zf_q    <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      per_q     <= per_d;
      num_q     <= num_d;
      zf_q      <= zf_d;
      tag_q     <= tag_d;
      valid_q   <= o_fir_en && tag_q[FIR_LATENCY-1];
      done_q    <= (state_q == StDone);
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign ov_addr      = addr_q;
  assign o_rom_en     = run_tick;
  assign o_fir_en     = pipe_q[ROM_LATENCY-1].tick;
  assign o_zero_fill  = pipe_q[ROM_LATENCY-1].tick && pipe_q[ROM_LATENCY-1].zero_fill;
  assign o_dout_valid = valid_q;
  assign o_busy       = (state_q == StRun) || (state_q == StDrain);
  assign o_done       = done_q;

endmodule
